traffic_light_ctrl: RTL and testbench

Controller FSM for a highway/farm-road intersection; the initiator side of the long/short interval timer. It issues one-cycle `trL`/`trS` start requests to the timer and advances on the timer's one-cycle `tL`/`tS` expiry pulses. A watchdog detects a timer that never answers and forces a latched fault state. Lights are decoded from state for the top-level lamp drivers.

---
 rtl/traffic_light_ctrl.sv | 122 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road intersection controller: drives long/short timer start
// requests, advances on expiry pulses, and latches FAULT if the timer stalls.
module traffic_light_ctrl #(
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       tL,
  input  logic       tS,
  output logic       trL,
  output logic       trS,
  output logic [1:0] hwy,
  output logic [1:0] farm,
  output logic       fault
);

  typedef enum logic [2:0] {HG, HY, FG, FY, FAULT} state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  state_t      state, nextState;
  logic        longDone, nextLongDone;
  logic        startPending;
  logic [31:0] wdog;
  logic        trig, tLv, tSv;
  logic        awaiting, expected, wdogExpire;
  logic        nextTrL, nextTrS;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HG;
      trL          <= 1'b0;
      trS          <= 1'b0;
      longDone     <= 1'b0;
      wdog         <= '0;
      startPending <= 1'b1;
    end else begin
      state        <= nextState;
      trL          <= nextTrL;
      trS          <= nextTrS;
      longDone     <= nextLongDone;
      startPending <= 1'b0;
      if (nextTrL || nextTrS)
        wdog <= '0;
      else if (awaiting && nextState != FAULT)
        wdog <= wdog + 32'd1;
    end
  end

  always_comb begin
    // Pulses arriving while a start request is on the wire belong to the
    // previous interval; the first post-reset cycle is treated the same way.
    trig     = trL | trS | startPending;
    tLv      = tL & ~trig;
    tSv      = tS & ~trig;
    awaiting = 1'b0;
    expected = 1'b0;
    case (state)
      HG: begin
        awaiting = ~longDone;
        expected = tLv;
      end
      HY, FY: begin
        awaiting = 1'b1;
        expected = tSv;
      end
      FG: begin
        awaiting = 1'b1;
        expected = tLv;
      end
      default: ;
    endcase
    wdogExpire = awaiting && (wdog == 32'(WDOG_CYCLES - 1)) && !expected;

    nextState = state;
    if (startPending)
      nextState = HG;
    else if (wdogExpire)
      nextState = FAULT;
    else begin
      case (state)
        HG:      if ((longDone || tLv) && car) nextState = HY;
        HY:      if (tSv) nextState = FG;
        FG:      if (tLv) nextState = FY;
        FY:      if (tSv) nextState = HG;
        default: nextState = FAULT;
      endcase
    end

    nextTrL = startPending ||
              (nextState != state && (nextState == HG || nextState == FG));
    nextTrS = nextState != state && (nextState == HY || nextState == FY);

    nextLongDone = longDone;
    if (nextTrL && nextState == HG)
      nextLongDone = 1'b0;
    else if (state == HG && tLv)
      nextLongDone = 1'b1;
  end

  always_comb begin
    hwy   = RED;
    farm  = RED;
    fault = 1'b0;
    case (state)
      HG: hwy = GREEN;
      HY: hwy = YELLOW;
      FG: farm = GREEN;
      FY: farm = YELLOW;
      FAULT: begin
        hwy   = YELLOW;
        farm  = YELLOW;
        fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: the bench plays the timer with fixed
// pulse timing and compares {hwy,farm,trL,trS,fault} every cycle.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       reset, car, tL, tS;
  logic       trL, trS, fault;
  logic [1:0] hwy, farm;

  int checks   = 0;
  int failures = 0;
  logic [6:0] sb[$];

  // {hwy, farm, trL, trS, fault}
  localparam logic [6:0] O_HG  = 7'b10_00_0_0_0;
  localparam logic [6:0] O_HGT = 7'b10_00_1_0_0;
  localparam logic [6:0] O_HY  = 7'b01_00_0_0_0;
  localparam logic [6:0] O_HYT = 7'b01_00_0_1_0;
  localparam logic [6:0] O_FG  = 7'b00_10_0_0_0;
  localparam logic [6:0] O_FGT = 7'b00_10_1_0_0;
  localparam logic [6:0] O_FY  = 7'b00_01_0_0_0;
  localparam logic [6:0] O_FYT = 7'b00_01_0_1_0;
  localparam logic [6:0] O_FLT = 7'b01_01_0_0_1;

  traffic_light_ctrl #(.WDOG_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .car   (car),
    .tL    (tL),
    .tS    (tS),
    .trL   (trL),
    .trS   (trS),
    .hwy   (hwy),
    .farm  (farm),
    .fault (fault)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then pop and compare once the DUT has produced them.
  task automatic st(input string tag, input logic r, input logic c,
                    input logic l, input logic s, input logic [6:0] e);
    logic [6:0] exp, obs;
    reset = r;
    car   = c;
    tL    = l;
    tS    = s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    obs = {hwy, farm, trL, trS, fault};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // Starts in an HG trigger cycle, ends in the next HG trigger cycle.
  task automatic cycleNominal(input logic spur);
    for (int k = 0; k < 5; k++)
      st("hg", 1'b0, 1'b1, spur && k == 0, spur && k == 2, O_HG);
    st("hg2hy", 1'b0, 1'b1, 1'b1, 1'b0, O_HYT);
    repeat (2) st("hy", 1'b0, 1'b1, 1'b0, 1'b0, O_HY);
    st("hy2fg", 1'b0, 1'b1, 1'b0, 1'b1, O_FGT);
    for (int k = 0; k < 5; k++)
      st("fg", 1'b0, !(spur && k == 1), 1'b0, 1'b0, O_FG);
    st("fg2fy", 1'b0, 1'b1, 1'b1, 1'b0, O_FYT);
    for (int k = 0; k < 2; k++)
      st("fy", 1'b0, 1'b1, spur && k == 1, 1'b0, O_FY);
    st("fy2hg", 1'b0, 1'b1, 1'b0, 1'b1, O_HGT);
  endtask

  initial begin
    reset = 1'b1; car = 1'b0; tL = 1'b0; tS = 1'b0;
    repeat (2) st("reset", 1'b1, 1'b0, 1'b0, 1'b0, O_HG);
    st("release", 1'b0, 1'b1, 1'b0, 1'b0, O_HGT);

    cycleNominal(1'b0);
    cycleNominal(1'b1);

    // Late car: long interval expires with no car, HG waits unbounded.
    repeat (5) st("lc_hg", 1'b0, 1'b0, 1'b0, 1'b0, O_HG);
    st("lc_tl", 1'b0, 1'b0, 1'b1, 1'b0, O_HG);
    repeat (20) st("lc_wait", 1'b0, 1'b0, 1'b0, 1'b0, O_HG);
    st("lc_car", 1'b0, 1'b1, 1'b0, 1'b0, O_HYT);

    // Expected pulse on the last watchdog cycle beats the watchdog.
    repeat (15) st("race_hy", 1'b0, 1'b1, 1'b0, 1'b0, O_HY);
    st("race_ts", 1'b0, 1'b1, 1'b0, 1'b1, O_FGT);

    repeat (2) st("fg_pre", 1'b0, 1'b1, 1'b0, 1'b0, O_FG);
    st("rst_fg", 1'b1, 1'b1, 1'b0, 1'b0, O_HG);
    st("rel_fg", 1'b0, 1'b1, 1'b0, 1'b0, O_HGT);

    repeat (5) st("hg", 1'b0, 1'b1, 1'b0, 1'b0, O_HG);
    st("hg2hy", 1'b0, 1'b1, 1'b1, 1'b0, O_HYT);
    for (int k = 0; k < 15; k++)
      st("wd_hy", 1'b0, 1'b1, k == 7, 1'b0, O_HY);
    st("wd_fault", 1'b0, 1'b1, 1'b0, 1'b0, O_FLT);
    for (int k = 0; k < 10; k++)
      st("flt_hold", 1'b0, k[0], (k % 3) == 0, (k % 3) == 1, O_FLT);
    st("rst_flt", 1'b1, 1'b0, 1'b0, 1'b0, O_HG);
    st("rel_flt", 1'b0, 1'b1, 1'b0, 1'b0, O_HGT);

    // HG with no long expiry at all also trips the watchdog.
    repeat (15) st("wd_hg", 1'b0, 1'b1, 1'b0, 1'b0, O_HG);
    st("wd_hg_fault", 1'b0, 1'b1, 1'b0, 1'b0, O_FLT);
    st("rst2", 1'b1, 1'b0, 1'b0, 1'b0, O_HG);
    st("rel2", 1'b0, 1'b1, 1'b0, 1'b0, O_HGT);
    cycleNominal(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
